core_mem_arbiter: RTL and testbench

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

---
 rtl/core_mem_arbiter_if.sv | 54 +++++
 rtl/core_mem_arbiter.sv | 91 +++++++++
 tb/tb_core_mem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if: IMEM/DMEM/NOC requester ports and single RAM port of the node memory arbiter.
interface core_mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int RAM_AW = 10
);
  logic              imem_req_i;
  logic [AWIDTH-1:0] imem_addr_i;
  logic              imem_ack_o;
  logic [DWIDTH-1:0] imem_rdata_o;
  logic [1:0]        imem_resp_o;
  logic              dmem_req_i;
  logic              dmem_cmd_i;
  logic [1:0]        dmem_width_i;
  logic [AWIDTH-1:0] dmem_addr_i;
  logic [DWIDTH-1:0] dmem_wdata_i;
  logic              dmem_ack_o;
  logic [DWIDTH-1:0] dmem_rdata_o;
  logic [1:0]        dmem_resp_o;
  logic              noc_req_i;
  logic              noc_cmd_i;
  logic [1:0]        noc_width_i;
  logic [AWIDTH-1:0] noc_addr_i;
  logic [DWIDTH-1:0] noc_wdata_i;
  logic              noc_ack_o;
  logic [DWIDTH-1:0] noc_rdata_o;
  logic [1:0]        noc_resp_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [3:0]        ram_be_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic [DWIDTH-1:0] ram_wdata_o;
  logic [DWIDTH-1:0] ram_rdata_i;
  modport slave (
    input  imem_req_i, imem_addr_i,
    output imem_ack_o, imem_rdata_o, imem_resp_o,
    input  dmem_req_i, dmem_cmd_i, dmem_width_i, dmem_addr_i, dmem_wdata_i,
    output dmem_ack_o, dmem_rdata_o, dmem_resp_o,
    input  noc_req_i, noc_cmd_i, noc_width_i, noc_addr_i, noc_wdata_i,
    output noc_ack_o, noc_rdata_o, noc_resp_o,
    output ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );
  modport master (
    output imem_req_i, imem_addr_i,
    input  imem_ack_o, imem_rdata_o, imem_resp_o,
    output dmem_req_i, dmem_cmd_i, dmem_width_i, dmem_addr_i, dmem_wdata_i,
    input  dmem_ack_o, dmem_rdata_o, dmem_resp_o,
    output noc_req_i, noc_cmd_i, noc_width_i, noc_addr_i, noc_wdata_i,
    input  noc_ack_o, noc_rdata_o, noc_resp_o,
    input  ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin NOC/DMEM/IMEM arbitration onto one local RAM port,
// three cycles per access (IDLE latch, ACC ack + RAM strobe, RESP data).
module core_mem_arbiter #(
  parameter int NODE_ID = 0,
  parameter int SIZE    = 512,
  parameter int BYTE    = 8,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  localparam int RAM_AW = $clog2(SIZE * BYTE / 4)
) (
  input logic clk,
  input logic rst,
  core_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_e;
  localparam logic [AWIDTH-1:0] BASE = AWIDTH'(NODE_ID * SIZE * BYTE);
  localparam logic [AWIDTH-1:0] WIN  = AWIDTH'(SIZE * BYTE);
  state_e state_q, state_d;
  logic [1:0] prio_q, prio_d, sel_q, sel_d, win, c2, c3, wid_q, wid_d, rc;
  logic cmd_q, cmd_d, err, acc, rsp;
  logic [AWIDTH-1:0] addr_q, addr_d, off;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rd;
  logic [2:0] req;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  // requester index: 0 NOC, 1 DMEM, 2 IMEM; prio_q holds the currently highest one
  assign req = {bus.imem_req_i, bus.dmem_req_i, bus.noc_req_i};
  assign c2  = nxt(prio_q);
  assign c3  = nxt(c2);
  assign win = req[prio_q] ? prio_q : req[c2] ? c2 : c3;
  // addresses below BASE wrap to large offsets, so one compare covers both window edges
  assign off = addr_q - BASE;
  assign err = off >= WIN || wid_q == 2'b11 || (wid_q == 2'b01 && addr_q[0]) ||
               (wid_q == 2'b10 && addr_q[1:0] != 2'b00);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 2'd0;
      sel_q   <= 2'd0;
      cmd_q   <= 1'b0;
      wid_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      cmd_q   <= cmd_d;
      wid_q   <= wid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  always_comb begin
    state_d = state_q == ACC ? RESP : state_q == RESP ? IDLE : (|req ? ACC : IDLE);
    prio_d  = prio_q;
    sel_d   = sel_q;
    cmd_d   = cmd_q;
    wid_d   = wid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && |req) begin
      sel_d   = win;
      prio_d  = nxt(win);
      cmd_d   = win == 2'd0 ? bus.noc_cmd_i : win == 2'd1 ? bus.dmem_cmd_i : 1'b0;
      wid_d   = win == 2'd0 ? bus.noc_width_i : win == 2'd1 ? bus.dmem_width_i : 2'b10;
      addr_d  = win == 2'd0 ? bus.noc_addr_i : win == 2'd1 ? bus.dmem_addr_i : bus.imem_addr_i;
      wdata_d = win == 2'd0 ? bus.noc_wdata_i : win == 2'd1 ? bus.dmem_wdata_i : '0;
    end
  end
  assign acc = state_q == ACC;
  assign rsp = state_q == RESP;
  assign rc  = err ? 2'b10 : 2'b01;
  assign rd  = err ? '0 : bus.ram_rdata_i;
  assign bus.noc_ack_o    = acc && sel_q == 2'd0;
  assign bus.dmem_ack_o   = acc && sel_q == 2'd1;
  assign bus.imem_ack_o   = acc && sel_q == 2'd2;
  assign bus.noc_resp_o   = rsp && sel_q == 2'd0 ? rc : 2'b00;
  assign bus.dmem_resp_o  = rsp && sel_q == 2'd1 ? rc : 2'b00;
  assign bus.imem_resp_o  = rsp && sel_q == 2'd2 ? rc : 2'b00;
  assign bus.noc_rdata_o  = rsp && sel_q == 2'd0 ? rd : '0;
  assign bus.dmem_rdata_o = rsp && sel_q == 2'd1 ? rd : '0;
  assign bus.imem_rdata_o = rsp && sel_q == 2'd2 ? rd : '0;
  assign bus.ram_en_o    = acc && !err;
  assign bus.ram_we_o    = bus.ram_en_o && cmd_q;
  assign bus.ram_be_o    = !bus.ram_en_o ? 4'b0000 : wid_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                           wid_q == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
  assign bus.ram_addr_o  = acc ? off[RAM_AW+1:2] : '0;
  assign bus.ram_wdata_o = !acc ? '0 : wid_q == 2'b10 ? wdata_q : wdata_q << {addr_q[1:0], 3'b000};
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed vector table plus round-robin and reset corner sequences, node 1 window 0x1000-0x1FFF.
module tb_core_mem_arbiter;
  typedef struct {
    logic [1:0]  port;
    logic        cmd;
    logic [1:0]  wid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  be;
    logic [9:0]  raddr;
    logic [31:0] rwdata;
    logic [31:0] rdata;
  } vec_t;
  logic clk, rst, clr;
  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  int checks, fails;
  core_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32), .RAM_AW(10)) bus();
  core_mem_arbiter #(.NODE_ID(1), .SIZE(512), .BYTE(8), .AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // read-first synchronous RAM with byte-lane writes
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (bus.ram_en_o) begin
      rd_q <= mem[bus.ram_addr_o];
      if (bus.ram_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
    end
  end
  assign bus.ram_rdata_i = rd_q;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [2:0] acks();
    return {bus.imem_ack_o, bus.dmem_ack_o, bus.noc_ack_o};
  endfunction
  function automatic logic [1:0] resp_of(input logic [1:0] p);
    return p == 2'd0 ? bus.noc_resp_o : p == 2'd1 ? bus.dmem_resp_o : bus.imem_resp_o;
  endfunction
  function automatic logic [31:0] rdata_of(input logic [1:0] p);
    return p == 2'd0 ? bus.noc_rdata_o : p == 2'd1 ? bus.dmem_rdata_o : bus.imem_rdata_o;
  endfunction
  function automatic logic any_out();
    return |{acks(), bus.noc_resp_o, bus.dmem_resp_o, bus.imem_resp_o, bus.ram_en_o, bus.ram_we_o,
             bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o, bus.noc_rdata_o, bus.dmem_rdata_o, bus.imem_rdata_o};
  endfunction
  task automatic drive(input logic [1:0] p, input logic r, input logic c, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 2'd0) begin
      bus.noc_req_i = r; bus.noc_cmd_i = c; bus.noc_width_i = w; bus.noc_addr_i = a; bus.noc_wdata_i = d;
    end else if (p == 2'd1) begin
      bus.dmem_req_i = r; bus.dmem_cmd_i = c; bus.dmem_width_i = w; bus.dmem_addr_i = a; bus.dmem_wdata_i = d;
    end else begin
      bus.imem_req_i = r; bus.imem_addr_i = a;
    end
  endtask
  task automatic run(input vec_t t);
    int n;
    logic we;
    we = t.cmd && t.port != 2'd2 && !t.err;
    @(negedge clk);
    drive(t.port, 1'b1, t.cmd, t.wid, t.addr, t.wdata);
    @(negedge clk);
    n = 0;
    while (acks() == 3'b000 && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("ack_latency", n, 0);
    chk("ack_vec", {29'd0, acks()}, {29'd0, 3'b001 << t.port});
    chk("ram_en", {31'd0, bus.ram_en_o}, {31'd0, !t.err});
    if (!t.err) begin
      chk("ram_we", {31'd0, bus.ram_we_o}, {31'd0, we});
      chk("ram_be", {28'd0, bus.ram_be_o}, {28'd0, t.be});
      chk("ram_addr", {22'd0, bus.ram_addr_o}, {22'd0, t.raddr});
      if (we) chk("ram_wdata", bus.ram_wdata_o, t.rwdata);
    end
    drive(t.port, 1'b0, t.cmd, t.wid, t.addr, t.wdata);
    @(negedge clk);
    chk("resp", {30'd0, resp_of(t.port)}, t.err ? 32'd2 : 32'd1);
    chk("rdata", rdata_of(t.port), t.err ? 32'd0 : t.rdata);
    chk("other_resp", {26'd0, bus.noc_resp_o, bus.dmem_resp_o, bus.imem_resp_o} &
        ~(32'd3 << (2 * (2 - t.port))), 32'd0);
    @(negedge clk);
    chk("idle_quiet", {31'd0, any_out()}, 32'd0);
  endtask
  vec_t v [14];
  initial begin
    int n;
    checks = 0;
    fails  = 0;
    v[0]  = '{2'd1, 1'b1, 2'd2, 32'h1004, 32'hDEADBEEF, 1'b0, 4'hF, 10'd1,   32'hDEADBEEF, 32'h0};
    v[1]  = '{2'd1, 1'b0, 2'd2, 32'h1004, 32'h0,        1'b0, 4'hF, 10'd1,   32'h0,        32'hDEADBEEF};
    v[2]  = '{2'd1, 1'b1, 2'd0, 32'h1006, 32'h000000A5, 1'b0, 4'h4, 10'd1,   32'h00A50000, 32'hDEADBEEF};
    v[3]  = '{2'd1, 1'b0, 2'd2, 32'h1004, 32'h0,        1'b0, 4'hF, 10'd1,   32'h0,        32'hDEA5BEEF};
    v[4]  = '{2'd0, 1'b1, 2'd1, 32'h100A, 32'h00001234, 1'b0, 4'hC, 10'd2,   32'h12340000, 32'h0};
    v[5]  = '{2'd2, 1'b0, 2'd2, 32'h1008, 32'h0,        1'b0, 4'hF, 10'd2,   32'h0,        32'h12340000};
    v[6]  = '{2'd1, 1'b0, 2'd2, 32'h0000, 32'h0,        1'b1, 4'h0, 10'd0,   32'h0,        32'h0};
    v[7]  = '{2'd1, 1'b0, 2'd2, 32'h1002, 32'h0,        1'b1, 4'h0, 10'd0,   32'h0,        32'h0};
    v[8]  = '{2'd0, 1'b0, 2'd1, 32'h1001, 32'h0,        1'b1, 4'h0, 10'd0,   32'h0,        32'h0};
    v[9]  = '{2'd1, 1'b0, 2'd3, 32'h1000, 32'h0,        1'b1, 4'h0, 10'd0,   32'h0,        32'h0};
    v[10] = '{2'd1, 1'b0, 2'd2, 32'h2000, 32'h0,        1'b1, 4'h0, 10'd0,   32'h0,        32'h0};
    v[11] = '{2'd0, 1'b1, 2'd0, 32'h1FFF, 32'h00000077, 1'b0, 4'h8, 10'd1023, 32'h77000000, 32'h0};
    v[12] = '{2'd2, 1'b0, 2'd2, 32'h1FFC, 32'h0,        1'b0, 4'hF, 10'd1023, 32'h0,        32'h77000000};
    v[13] = '{2'd2, 1'b0, 2'd2, 32'h1002, 32'h0,        1'b1, 4'h0, 10'd0,   32'h0,        32'h0};
    rst = 1'b1;
    clr = 1'b1;
    for (int p = 0; p < 3; p++) drive(2'(p), 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset_quiet", {31'd0, any_out()}, 32'd0);
    rst = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 14; i++) run(v[i]);
    // all three requesters raised together right after reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) drive(2'(p), 1'b1, 1'b0, 2'd2, 32'h1000, 32'h0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("rr_cycle%0d", i), {29'd0, acks()},
          (i % 3 == 0) ? {29'd0, 3'b001 << ((i / 3) % 3)} : 32'd0);
    end
    for (int p = 0; p < 3; p++) drive(2'(p), 1'b0, 1'b0, 2'd2, 32'h1000, 32'h0);
    repeat (2) @(negedge clk);
    // reset during ACC of a write: write still lands
    drive(2'd1, 1'b1, 1'b1, 2'd2, 32'h1010, 32'hCAFEF00D);
    @(negedge clk);
    chk("rst_acc_en", {30'd0, bus.ram_en_o, bus.ram_we_o}, 32'd3);
    rst = 1'b1;
    drive(2'd1, 1'b0, 1'b1, 2'd2, 32'h1010, 32'hCAFEF00D);
    @(negedge clk);
    chk("rst_acc_dropped", {31'd0, any_out()}, 32'd0);
    rst = 1'b0;
    run('{2'd0, 1'b0, 2'd2, 32'h1010, 32'h0, 1'b0, 4'hF, 10'd4, 32'h0, 32'hCAFEF00D});
    // reset on the IDLE->ACC edge; priority was DMEM-first before it
    @(negedge clk);
    drive(2'd1, 1'b1, 1'b1, 2'd2, 32'h1014, 32'h11111111);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_edge_idle", {31'd0, any_out()}, 32'd0);
    rst = 1'b0;
    drive(2'd0, 1'b1, 1'b0, 2'd2, 32'h1014, 32'h0);
    @(negedge clk);
    chk("rst_edge_noc_first", {29'd0, acks()}, 32'd1);
    drive(2'd0, 1'b0, 1'b0, 2'd2, 32'h1014, 32'h0);
    @(negedge clk);
    chk("rst_edge_noc_resp", {30'd0, bus.noc_resp_o}, 32'd1);
    chk("rst_edge_no_write", bus.noc_rdata_o, 32'h0);
    n = 0;
    @(negedge clk);
    while (!bus.dmem_ack_o && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("rst_edge_dmem_later", {31'd0, bus.dmem_ack_o}, 32'd1);
    drive(2'd1, 1'b0, 1'b1, 2'd2, 32'h1014, 32'h11111111);
    repeat (2) @(negedge clk);
    run('{2'd0, 1'b0, 2'd2, 32'h1014, 32'h0, 1'b0, 4'hF, 10'd5, 32'h0, 32'h11111111});
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
